// File: rtl/fetch_pkg.sv
// Shared constants and types for the warp fetch scheduler.
// The flat-target packing convention is defined once here, in flat_slice().
package fetch_pkg;

   localparam int NUM_WARPS = 8;
   localparam int PC_W      = 32;
   localparam int WARP_ID_W = 3;
   localparam logic [PC_W-1:0] PC_INCR = 32'd4;

   typedef logic [PC_W-1:0]      pc_t;
   typedef logic [NUM_WARPS-1:0] warp_mask_t;
   typedef logic [WARP_ID_W-1:0] warp_id_t;

   // Warp w occupies bits [PC_W*w + PC_W-1 : PC_W*w] of a flat target bus.
   function automatic pc_t flat_slice(input logic [NUM_WARPS*PC_W-1:0] flat,
                                      input warp_id_t w);
      return flat[int'(w)*PC_W +: PC_W];
   endfunction

endpackage

// File: rtl/warp_fetch_scheduler_if.sv
// Request/grant bundle between the fetch scheduler (master) and its
// round-robin arbiter (slave).
interface warp_fetch_scheduler_if;
   import fetch_pkg::*;

   warp_mask_t req;
   warp_id_t   ptr;
   warp_mask_t grant;
   warp_id_t   grant_id;
   logic       grant_valid;

   modport master (output req, ptr, input grant, grant_id, grant_valid);
   modport slave  (input req, ptr, output grant, grant_id, grant_valid);

endinterface

// File: rtl/rr_arbiter8.sv
// Combinational 8-way round-robin arbiter: grants the first requester found
// scanning ptr, ptr+1, ... with wrap-around.
module rr_arbiter8
   import fetch_pkg::*;
(
   warp_fetch_scheduler_if.slave arb
);

   warp_mask_t grant;
   warp_id_t   grant_id;
   logic       grant_valid;
   warp_id_t   idx;

   always_comb begin
      // NOTE: every output gets a default before the loop so no path leaves it unassigned (no latch).
      grant       = '0;
      grant_id    = '0;
      grant_valid = 1'b0;
      idx         = '0;
      for (int i = 0; i < 8; i++) begin
         idx = arb.ptr + warp_id_t'(i);
         if (!grant_valid && arb.req[idx]) begin
            grant_valid = 1'b1;
            grant_id    = idx;
            grant[idx]  = 1'b1;
         end
      end
   end

   assign arb.grant       = grant;
   assign arb.grant_id    = grant_id;
   assign arb.grant_valid = grant_valid;

endmodule

// File: rtl/warp_fetch_scheduler.sv
// Per-warp PC/active tracking with round-robin fetch issue; the grant made in
// one cycle is presented on the fetch outputs, registered, in the next.
module warp_fetch_scheduler #(
   parameter int NUM_WARPS = fetch_pkg::NUM_WARPS,
   parameter int PC_W      = fetch_pkg::PC_W
) (
   input  logic                      clk,
   input  logic                      rst,
   input  logic [2:0]                WarpID_TM_PC,
   input  logic                      UpdatePC_TM_PC,
   input  logic [PC_W-1:0]           StartingPC_TM_PC,
   input  logic [NUM_WARPS-1:0]      UpdatePC_Qual1_SIMT_PC,
   input  logic [NUM_WARPS*PC_W-1:0] TargetAddr_ALU_PC_Flat,
   input  logic [NUM_WARPS-1:0]      UpdatePC_Qual2_SIMT_PC,
   input  logic [NUM_WARPS*PC_W-1:0] TargetAddr_SIMT_PC_Flat,
   input  logic [NUM_WARPS-1:0]      Stall_SIMT_PC,
   input  logic [NUM_WARPS-1:0]      Req_IB_PC,
   input  logic [NUM_WARPS-1:0]      Exit_IB_PC,
   output logic [PC_W-1:0]           PC_IF_ICache,
   output logic [NUM_WARPS-1:0]      Valid_IF_IB,
   output logic [2:0]                WarpID_IF_IB,
   output logic [PC_W-1:0]           PCplus4_IF_ID,
   output logic [NUM_WARPS-1:0]      Active_PC
);
   import fetch_pkg::*;

   localparam logic [PC_W-1:0] INCR = PC_W'(PC_INCR);

   logic [PC_W-1:0]      pc_q [NUM_WARPS];
   logic [PC_W-1:0]      pc_d [NUM_WARPS];
   logic [NUM_WARPS-1:0] active_q, active_d;
   warp_id_t             ptr_q, ptr_d;
   logic [NUM_WARPS-1:0] valid_q, valid_d;
   warp_id_t             wid_q, wid_d;
   logic [PC_W-1:0]      fetch_pc_q, fetch_pc_d;
   logic [PC_W-1:0]      pcp4_q, pcp4_d;

   logic [NUM_WARPS-1:0] launch, any_update, eligible;

   warp_fetch_scheduler_if arb_bus ();

   rr_arbiter8 u_arb (.arb(arb_bus.slave));

   // A warp whose PC or liveness changes this cycle must not fetch with a stale PC.
   always_comb begin
      launch = '0;
      if (UpdatePC_TM_PC) launch[WarpID_TM_PC] = 1'b1;
      any_update = launch | UpdatePC_Qual1_SIMT_PC | UpdatePC_Qual2_SIMT_PC | Exit_IB_PC;
      eligible   = active_q & Req_IB_PC & ~Stall_SIMT_PC & ~any_update;
   end

   assign arb_bus.req = eligible;
   assign arb_bus.ptr = ptr_q;

   always_comb begin
      for (int w = 0; w < NUM_WARPS; w++) begin
         pc_d[w] = pc_q[w];
         if (launch[w])
            pc_d[w] = StartingPC_TM_PC;
         else if (UpdatePC_Qual2_SIMT_PC[w])
            pc_d[w] = flat_slice(TargetAddr_SIMT_PC_Flat, warp_id_t'(w));
         else if (UpdatePC_Qual1_SIMT_PC[w])
            pc_d[w] = flat_slice(TargetAddr_ALU_PC_Flat, warp_id_t'(w));
         else if (arb_bus.grant[w])
            pc_d[w] = pc_q[w] + INCR;
      end

      active_d   = launch | (active_q & ~Exit_IB_PC);
      ptr_d      = ptr_q;
      valid_d    = '0;
      wid_d      = wid_q;
      fetch_pc_d = fetch_pc_q;
      pcp4_d     = pcp4_q;
      if (arb_bus.grant_valid) begin
         ptr_d      = arb_bus.grant_id + warp_id_t'(1);
         valid_d    = arb_bus.grant;
         wid_d      = arb_bus.grant_id;
         fetch_pc_d = pc_q[arb_bus.grant_id];
         pcp4_d     = pc_q[arb_bus.grant_id] + INCR;
      end
   end

   // NOTE: sequential state uses non-blocking assignment so every register samples pre-edge values.
   always_ff @(posedge clk) begin
      if (rst) begin
         // NOTE: the PC file is a small register array, reset explicitly so fetch addresses are defined.
         for (int w = 0; w < NUM_WARPS; w++) pc_q[w] <= '0;
         active_q   <= '0;
         ptr_q      <= '0;
         valid_q    <= '0;
         wid_q      <= '0;
         fetch_pc_q <= '0;
         pcp4_q     <= INCR;
      end else begin
         for (int w = 0; w < NUM_WARPS; w++) pc_q[w] <= pc_d[w];
         active_q   <= active_d;
         ptr_q      <= ptr_d;
         valid_q    <= valid_d;
         wid_q      <= wid_d;
         fetch_pc_q <= fetch_pc_d;
         pcp4_q     <= pcp4_d;
      end
   end

   assign PC_IF_ICache  = fetch_pc_q;
   assign Valid_IF_IB   = valid_q;
   assign WarpID_IF_IB  = wid_q;
   assign PCplus4_IF_ID = pcp4_q;
   assign Active_PC     = active_q;

endmodule

// File: doc/warp_fetch_scheduler.md
WARP_FETCH_SCHEDULER -- requirements
Module: warp_fetch_scheduler

Interface
REQ-001 SHALL have parameter NUM_WARPS, default 8, number of warp contexts.
REQ-002 SHALL have parameter PC_W, default 32, PC width in bits.
REQ-003 SHALL have port clk  in  1  sole clock; all state updates on rising edge.
REQ-004 SHALL have port rst  in  1  reset, synchronous, active-high.
REQ-005 SHALL have port WarpID_TM_PC  in  3  warp being launched by task manager.
REQ-006 SHALL have port UpdatePC_TM_PC  in  1  launch strobe; loads StartingPC and activates warp.
REQ-007 SHALL have port StartingPC_TM_PC  in  32  launch PC.
REQ-008 SHALL have port UpdatePC_Qual1_SIMT_PC  in  8  per-warp branch-resolved redirect.
REQ-009 SHALL have port TargetAddr_ALU_PC_Flat  in  256  8x32 redirect targets; warp w at bits [32w+31:32w].
REQ-010 SHALL have port UpdatePC_Qual2_SIMT_PC  in  8  per-warp SIMT-stack redirect (reconvergence/ret).
REQ-011 SHALL have port TargetAddr_SIMT_PC_Flat  in  256  8x32 SIMT targets, same packing.
REQ-012 SHALL have port Stall_SIMT_PC  in  8  per-warp fetch block.
REQ-013 SHALL have port Req_IB_PC  in  8  per-warp I-buffer has space.
REQ-014 SHALL have port Exit_IB_PC  in  8  per-warp exit retired; deactivates warp.
REQ-015 SHALL have port PC_IF_ICache  out  32  fetch address.
REQ-016 SHALL have port Valid_IF_IB  out  8  one-hot fetch valid, zero when idle.
REQ-017 SHALL have port WarpID_IF_IB  out  3  binary ID of fetching warp.
REQ-018 SHALL have port PCplus4_IF_ID  out  32  PC_IF_ICache+4, for SIMT PCplus4 path.
REQ-019 SHALL have port Active_PC  out  8  per-warp active mask.

Function
REQ-020 SHALL hold per-warp PC[w] (32b) and Active[w]; Active_PC mirrors Active directly.
REQ-021 Eligible[w] SHALL = Active[w] & Req_IB_PC[w] & ~Stall_SIMT_PC[w] & ~AnyUpdate[w], AnyUpdate = TM launch for w | Qual1[w] | Qual2[w] | Exit_IB_PC[w].
REQ-022 SHALL grant at most one eligible warp per cycle, round-robin: first eligible index scanning ptr, ptr+1, ... modulo 8.
REQ-023 On grant g, ptr SHALL become (g+1) mod 8; no grant leaves ptr unchanged.
REQ-024 Grant in cycle N SHALL appear registered in cycle N+1: Valid_IF_IB=1<<g, WarpID_IF_IB=g, PC_IF_ICache=PC[g] sampled in N, PCplus4_IF_ID=that+4; no grant -> Valid_IF_IB=0, others hold.
REQ-025 Granted warp SHALL update PC[g]<=PC[g]+4 at end of cycle N, modulo 2^32 (0xFFFFFFFC -> 0x00000000).
REQ-026 PC write priority per warp per cycle SHALL be: TM launch > Qual2 target > Qual1 target > +4 increment.
REQ-027 TM launch SHALL set Active[w]=1 and PC[w]=StartingPC; launch wins over same-cycle Exit.
REQ-028 Exit_IB_PC[w] SHALL clear Active[w]; PC[w] holds; exit of inactive warp is no-op.
REQ-029 Redirect to inactive warp SHALL update PC[w] but not activate it.
REQ-030 Redirect/exit SHALL never cancel an output already registered in the prior cycle; downstream flushes it.
REQ-031 Stall or Req deassert SHALL take effect same cycle: that warp is not granted in that cycle.

Reset
REQ-032 When rst=1 at clock edge: all PC[w]=0, Active=0, ptr=0, Valid_IF_IB=0, WarpID_IF_IB=0, PC_IF_ICache=0, PCplus4_IF_ID=4.
REQ-033 rst SHALL override every same-cycle launch, redirect and grant; first grant possible in cycle after rst deasserts with a warp active.

Structure
REQ-034 Package fetch_pkg SHALL hold NUM_WARPS, PC_W, WARP_ID_W=3, PC_INCR=4 and the flat-target slice convention.
REQ-035 Arbitration SHALL be sub-module rr_arbiter8 (req[7:0], ptr[2:0] -> grant one-hot, grant_id, grant_valid), purely combinational.

Verification
REQ-036 Launch warps 0,3,5 at 0x100,0x200,0x300, Req=0xFF -> Valid sequence 0x01,0x08,0x20,0x01; PCs 0x100,0x200,0x300,0x104.
REQ-037 Warp 3 Qual1 (0x400) and Qual2 (0x800) same cycle -> warp 3 skipped that cycle, next fetch of warp 3 at 0x800.
REQ-038 Stall_SIMT_PC=0x08 with warps 0,3 active -> only warp 0 fetched (0x100,0x104,...) until stall drops.
REQ-039 Warp 0 PC 0xFFFFFFFC fetched -> next fetch PC 0x00000000, PCplus4_IF_ID 0x00000004.
REQ-040 rst asserted mid-stream while Valid_IF_IB=0x08 -> next cycle Valid=0, Active_PC=0, PC_IF_ICache=0; Exit + launch same warp same cycle -> warp stays active at StartingPC.
